// File: rtl/sprite_linebuf_scanout_pkg.sv
// Shared constants and types for the sprite line-buffer scanout block.
package sprite_linebuf_scanout_pkg;

  localparam int unsigned LB_ADDR_W = 9;
  localparam int unsigned LB_DATA_W = 8;
  localparam int unsigned LB_DEPTH  = 512;

  localparam logic [3:0] TRANSPARENT_CODE = 4'h0;

  typedef enum logic {
    CLR,
    RUN
  } lb_state_e;

endpackage

// File: rtl/sprite_linebuf_scanout_if.sv
// Pixel scanout and sprite-writer signal bundle for sprite_linebuf_scanout.
interface sprite_linebuf_scanout_if;
  import sprite_linebuf_scanout_pkg::*;

  logic                 pixel_ce;
  logic                 line_sync;
  logic [LB_ADDR_W-1:0] hpix;
  logic                 screen_flip;
  logic                 wr_en;
  logic [LB_ADDR_W-1:0] wr_addr;
  logic [LB_DATA_W-1:0] wr_data;
  logic [LB_DATA_W-1:0] pix_out;
  logic                 init_done;
  logic                 disp_bank;

  modport master (
    output pixel_ce, line_sync, hpix, screen_flip, wr_en, wr_addr, wr_data,
    input  pix_out, init_done, disp_bank
  );

  modport slave (
    input  pixel_ce, line_sync, hpix, screen_flip, wr_en, wr_addr, wr_data,
    output pix_out, init_done, disp_bank
  );

endinterface

// File: rtl/sprite_lb_bank.sv
// Single-port 512x8 line-buffer RAM with synchronous read; output holds across writes.
module sprite_lb_bank
  import sprite_linebuf_scanout_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [LB_ADDR_W-1:0] i_addr,
  input  logic [LB_DATA_W-1:0] i_wdata,
  output logic [LB_DATA_W-1:0] o_rdata
);

  logic [LB_DATA_W-1:0] r_mem [LB_DEPTH];
  logic [LB_DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sprite_linebuf_scanout.sv
// Double-banked sprite line buffer: renderer fills one bank while the other is scanned out.
// Clear-behind of displayed pixels is compiled in with the macro SPR_LB_CLEAR_EN.
module sprite_linebuf_scanout
  import sprite_linebuf_scanout_pkg::*;
(
  input  logic                     master_clk,
  input  logic                     reset,
  sprite_linebuf_scanout_if.slave  bus
);

`ifdef SPR_LB_CLEAR_EN
  localparam bit ClearBehindEn = 1'b1;
`else
  localparam bit ClearBehindEn = 1'b0;
`endif

  lb_state_e            r_state, w_state_next;
  logic [LB_ADDR_W-1:0] r_sweep;
  logic                 r_sync_q;
  logic                 r_disp_bank;
  logic                 r_init_done;
  logic [LB_ADDR_W-1:0] r_rd_addr;
  logic                 r_rd_bank;
  logic                 r_rd_pend;
  logic [LB_DATA_W-1:0] r_rd_data;
  logic [LB_DATA_W-1:0] r_pix_out;

  logic                 w_run;
  logic                 w_toggle;
  logic                 w_pix_rd;
  logic                 w_wr_pix;
  logic [LB_ADDR_W-1:0] w_rd_addr;

  logic [1:0]                w_en;
  logic [1:0]                w_we;
  logic [1:0][LB_ADDR_W-1:0] w_addr;
  logic [1:0][LB_DATA_W-1:0] w_wdata;
  logic [1:0][LB_DATA_W-1:0] w_rdata;

  assign w_run     = (r_state == RUN);
  assign w_toggle  = w_run & bus.line_sync & ~r_sync_q;
  assign w_pix_rd  = w_run & bus.pixel_ce;
  assign w_wr_pix  = w_run & bus.wr_en & (bus.wr_data[7:4] != TRANSPARENT_CODE);
  assign w_rd_addr = bus.screen_flip ? (9'h1FF - bus.hpix) : bus.hpix;

  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_state <= CLR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CLR:     if (r_sweep == 9'h1FF) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = CLR;
    endcase
  end

  // Display bank serves reads and clear-behind; write bank serves the renderer only.
  always_comb begin
    w_en    = '0;
    w_we    = '0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (r_state)
      CLR: begin
        w_en      = 2'b11;
        w_we      = 2'b11;
        w_addr[0] = r_sweep;
        w_addr[1] = r_sweep;
      end
      RUN: begin
        if (w_pix_rd) begin
          w_en[r_disp_bank]   = 1'b1;
          w_addr[r_disp_bank] = w_rd_addr;
        end else if (ClearBehindEn && r_rd_pend && (r_rd_bank == r_disp_bank)) begin
          w_en[r_disp_bank]   = 1'b1;
          w_we[r_disp_bank]   = 1'b1;
          w_addr[r_disp_bank] = r_rd_addr;
        end
        if (w_wr_pix) begin
          w_en[~r_disp_bank]    = 1'b1;
          w_we[~r_disp_bank]    = 1'b1;
          w_addr[~r_disp_bank]  = bus.wr_addr;
          w_wdata[~r_disp_bank] = bus.wr_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge master_clk) begin
    if (reset) begin
      r_sweep     <= '0;
      r_sync_q    <= 1'b0;
      r_disp_bank <= 1'b0;
      r_init_done <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_rd_data   <= '0;
      r_pix_out   <= '0;
    end else begin
      r_sync_q    <= bus.line_sync;
      r_init_done <= w_run;
      r_rd_pend   <= w_pix_rd;
      if (!w_run) begin
        r_sweep <= r_sweep + 9'd1;
      end
      if (w_toggle) begin
        r_disp_bank <= ~r_disp_bank;
      end
      if (w_pix_rd) begin
        r_rd_addr <= w_rd_addr;
        r_rd_bank <= r_disp_bank;
        r_pix_out <= {r_rd_data[3:0], r_rd_data[7:4]};
      end
      // Capture from the bank the read was issued to, even if banks swapped since.
      if (r_rd_pend) begin
        r_rd_data <= w_rdata[r_rd_bank];
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    sprite_lb_bank u_bank (
      .i_clk   (master_clk),
      .i_en    (w_en[gi]),
      .i_we    (w_we[gi]),
      .i_addr  (w_addr[gi]),
      .i_wdata (w_wdata[gi]),
      .o_rdata (w_rdata[gi])
    );
  end

  assign bus.pix_out   = r_pix_out;
  assign bus.init_done = r_init_done;
  assign bus.disp_bank = r_disp_bank;

endmodule

// File: tb/tb_sprite_linebuf_scanout.sv
// Scoreboard bench for sprite_linebuf_scanout against a bank-array reference model.
module tb_sprite_linebuf_scanout;
  import sprite_linebuf_scanout_pkg::*;

`ifdef SPR_LB_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic master_clk = 1'b0;
  logic reset;
  always #5 master_clk = ~master_clk;

  sprite_linebuf_scanout_if bus ();

  sprite_linebuf_scanout dut (
    .master_clk (master_clk),
    .reset      (reset),
    .bus        (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] exp_q [$];

  logic [7:0] m_mem [2][512];
  logic       m_disp;
  logic [7:0] m_pend;
  logic       m_sync;
  int         m_clr_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One master_clk cycle: drive inputs, advance the model, wait to the next negedge.
  task automatic step(input logic rst, input logic ce, input logic sync, input logic flip,
                      input logic we, input logic [8:0] hp, input logic [8:0] wa,
                      input logic [7:0] wd);
    logic [8:0] a;
    reset           = rst;
    bus.pixel_ce    = ce;
    bus.line_sync   = sync;
    bus.screen_flip = flip;
    bus.hpix        = hp;
    bus.wr_en       = we;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    if (rst) begin
      if (ce) exp_q.push_back(8'h00);
      m_clr_left = 512;
      m_disp     = 1'b0;
      m_pend     = 8'h00;
      m_sync     = 1'b0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 512; i++) m_mem[b][i] = 8'h00;
    end else begin
      if (m_clr_left > 0) begin
        m_clr_left--;
        if (ce) exp_q.push_back(8'h00);
      end else begin
        if (ce) begin
          exp_q.push_back({m_pend[3:0], m_pend[7:4]});
          a = flip ? 9'(9'h1FF - hp) : hp;
          m_pend = m_mem[m_disp][a];
          if (ClearEn) m_mem[m_disp][a] = 8'h00;
        end
        if (we && wd[7:4] != 4'h0) m_mem[!m_disp][wa] = wd;
        if (sync && !m_sync) m_disp = !m_disp;
      end
      m_sync = sync;
    end
    @(posedge master_clk);
    @(negedge master_clk);
  endtask

  task automatic idle(input logic sync);
    step(1'b0, 1'b0, sync, 1'b0, 1'b0, 9'd0, 9'd0, 8'h00);
  endtask

  task automatic wr(input logic [8:0] wa, input logic [7:0] wd);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, wa, wd);
  endtask

  task automatic toggle_bank();
    idle(1'b1);
    idle(1'b0);
  endtask

  // Counts cycles from reset release to init_done while throwing junk inputs at the DUT.
  task automatic wait_init();
    int cnt = 0;
    while (!bus.init_done && cnt < 2000) begin
      step(1'b0, cnt[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
           9'($urandom), 9'($urandom), 8'($urandom));
      cnt++;
      chk("sweep_pix_zero", {24'd0, bus.pix_out}, 32'h0);
    end
    chk("init_latency", cnt, 513);
    chk("init_bank", {31'd0, bus.disp_bank}, 32'd0);
    idle(1'b0);
  endtask

  task automatic scan(input logic flip, input int p0, input logic [7:0] e0,
                      input int p1, input logic [7:0] e1);
    for (int h = 0; h < 512; h++) begin
      step(1'b0, 1'b1, 1'b0, flip, 1'b0, 9'(h), 9'd0, 8'h00);
      if (h == p0 + 1) chk("probe_a", {24'd0, bus.pix_out}, {24'd0, e0});
      if (h == p1 + 1) chk("probe_b", {24'd0, bus.pix_out}, {24'd0, e1});
      idle(1'b0);
    end
  endtask

  // Monitor: every accepted pixel_ce must produce the next queued pixel.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge master_clk);
      if (bus.pixel_ce === 1'b1) begin
        #1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL pix_out: got %0h with no expectation queued at %0t",
                   bus.pix_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pix_out", {24'd0, bus.pix_out}, {24'd0, e});
        end
      end
    end
  end

  initial begin
    logic sync_lvl;
    int   gap;
    m_clr_left = 512;
    reset = 1'b1;
    bus.pixel_ce = 1'b0; bus.line_sync = 1'b0; bus.screen_flip = 1'b0; bus.hpix = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    @(negedge master_clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 8'h00);
    chk("rst_pix", {24'd0, bus.pix_out}, 32'h0);
    chk("rst_init", {31'd0, bus.init_done}, 32'd0);
    chk("rst_bank", {31'd0, bus.disp_bank}, 32'd0);

    // Reset mid-sweep, then the full sweep must run again.
    repeat (300) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0, 9'($urandom), 8'($urandom));
    chk("sweep_busy", {31'd0, bus.init_done}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 8'h00);
    wait_init();

    // Transparency and scanout.
    wr(9'd100, 8'hA3);
    wr(9'd101, 8'h05);
    toggle_bank();
    chk("bank_after_tog1", {31'd0, bus.disp_bank}, 32'd1);
    scan(1'b0, 100, 8'h3A, 101, 8'h00);
    scan(1'b0, 100, ClearEn ? 8'h00 : 8'h3A, 101, 8'h00);

    // Flip addressing on the other bank.
    wr(9'd100, 8'hA3);
    wr(9'd101, 8'h05);
    toggle_bank();
    chk("bank_after_tog2", {31'd0, bus.disp_bank}, 32'd0);
    scan(1'b1, 411, 8'h3A, 412, 8'h00);

    // Write coincident with the bank swap lands in the newly displayed bank.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'd0, 9'd7, 8'hC9);
    idle(1'b0);
    chk("bank_after_tog3", {31'd0, bus.disp_bank}, 32'd1);
    scan(1'b0, 7, 8'h9C, 100, ClearEn ? 8'h00 : 8'h3A);
    toggle_bank();
    scan(1'b0, 7, 8'h00, 100, ClearEn ? 8'h00 : 8'h3A);

    // Randomized traffic on a narrow address window so reads hit written pixels.
    sync_lvl = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      step(1'b0, 1'b1, sync_lvl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           9'($urandom_range(0, 31)), 9'($urandom_range(0, 31)), 8'($urandom));
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 15) == 0) sync_lvl = !sync_lvl;
        step(1'b0, 1'b0, sync_lvl, 1'b0, 1'($urandom_range(0, 1)), 9'd0,
             9'($urandom_range(0, 31)), 8'($urandom));
      end
    end
    idle(1'b0);
    chk("bank_random", {31'd0, bus.disp_bank}, {31'd0, m_disp});

    // Reset during scanout at hpix=200.
    wr(9'd199, 8'hB7);
    toggle_bank();
    for (int h = 0; h <= 200; h++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'(h), 9'd0, 8'h00);
      idle(1'b0);
    end
    chk("pre_reset_pix", {24'd0, bus.pix_out}, 32'h7B);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 9'd0, 8'h00);
    chk("midline_rst_pix", {24'd0, bus.pix_out}, 32'h0);
    chk("midline_rst_init", {31'd0, bus.init_done}, 32'd0);
    chk("midline_rst_bank", {31'd0, bus.disp_bank}, 32'd0);
    wait_init();
    scan(1'b0, 199, 8'h00, 100, 8'h00);
    toggle_bank();
    scan(1'b0, 199, 8'h00, 7, 8'h00);

    repeat (4) idle(1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
